// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;
  typedef enum logic {IDLE, CALC} state_t;

  localparam int DIV_WIDTH = 8;
  // Wide enough for any WIDTH; the top slices off what it needs.
  localparam logic [63:0] ALL_ONES = '1;
endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into P,
// trial-subtract the divisor and record the quotient bit.
module seq_divider_div_step #(parameter int WIDTH = 8) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] t;
  logic           unused_p_msb;

  // P stays below the divisor between steps, so its MSB never carries data.
  assign unused_p_msb = p[WIDTH];
  assign t = {p[WIDTH-1:0], q[WIDTH-1]};

  always_comb begin
    p_nxt = t;
    q_nxt = {q[WIDTH-2:0], 1'b0};
    if (t >= {1'b0, divisor}) begin
      p_nxt = t - {1'b0, divisor};
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// SEQ_DIVIDER_EARLY_EXIT_EN: finish immediately when divisor > dividend.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_divider_if.slave   bus
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p, p_nxt;
  logic [WIDTH-1:0] q, q_nxt, dvs;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             done_r, dbz_r;
  logic             accept, zero_div, short_div, last;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .p(p), .q(q), .divisor(dvs), .p_nxt(p_nxt), .q_nxt(q_nxt)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_div  = 1'b0;
    short_div = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        zero_div = (bus.divisor == '0);
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
        short_div = !zero_div && (bus.divisor > bus.dividend);
`else
        short_div = 1'b0;
`endif
        if (!zero_div && !short_div) state_nxt = CALC;
      end
      CALC: begin
        last = (cnt == CNT_W'(WIDTH-1));
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      p      <= '0;
      q      <= '0;
      dvs    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        if (zero_div) begin
          quot_r <= ALL_ONES[WIDTH-1:0];
          rem_r  <= bus.dividend;
          dbz_r  <= 1'b1;
          done_r <= 1'b1;
        end else if (short_div) begin
          quot_r <= '0;
          rem_r  <= bus.dividend;
          dbz_r  <= 1'b0;
          done_r <= 1'b1;
        end else begin
          q     <= bus.dividend;
          p     <= '0;
          cnt   <= '0;
          dvs   <= bus.divisor;
          dbz_r <= 1'b0;
        end
      end else if (state == CALC) begin
        p   <= p_nxt;
        q   <= q_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          quot_r <= q_nxt;
          rem_r  <= p_nxt[WIDTH-1:0];
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int WIDTH = 8;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   done_seen = 0;

  seq_divider_if #(.WIDTH(WIDTH)) dif ();
  seq_divider #(.WIDTH(WIDTH), .CNT_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(dif));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-operation arithmetic with a cycle countdown.
  logic             e_busy = 0, e_done = 0, e_dbz = 0;
  logic [WIDTH-1:0] e_q = 0, e_r = 0, pq = 0, pr = 0;
  int               e_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_busy <= 0; e_done <= 0; e_dbz <= 0; e_q <= 0; e_r <= 0; e_cnt <= 0;
    end else begin
      e_done <= 0;
      if (e_busy) begin
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1) begin
          e_busy <= 0; e_done <= 1; e_q <= pq; e_r <= pr;
        end
      end else if (dif.start) begin
        if (dif.divisor == 0) begin
          e_q <= '1; e_r <= dif.dividend; e_dbz <= 1; e_done <= 1;
        end else if (EARLY && dif.divisor > dif.dividend) begin
          e_q <= 0; e_r <= dif.dividend; e_dbz <= 0; e_done <= 1;
        end else begin
          e_busy <= 1; e_cnt <= WIDTH; e_dbz <= 0;
          pq <= dif.dividend / dif.divisor;
          pr <= dif.dividend % dif.divisor;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("busy", dif.busy, e_busy);
    check("done", dif.done, e_done);
    check("quotient", dif.quotient, e_q);
    check("remainder", dif.remainder, e_r);
    check("div_by_zero", dif.div_by_zero, e_dbz);
    if (dif.done) done_seen++;
  end

  // Call at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dif.start = 1; dif.dividend = a; dif.divisor = b;
    @(negedge clk);
    dif.start = 0;
  endtask

  // Counts edges after the accepting edge until done; bounded.
  task automatic wait_done(input int exp_lat, input string name);
    int k = 0;
    while (!dif.done && k < 20) begin @(negedge clk); k++; end
    check({name, "_latency"}, k, exp_lat);
  endtask

  initial begin
    reset_n = 0; dif.start = 0; dif.dividend = 0; dif.divisor = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", dif.busy, 0);
    check("reset_done", dif.done, 0);
    check("reset_quot", dif.quotient, 0);
    check("reset_rem", dif.remainder, 0);
    check("reset_dbz", dif.div_by_zero, 0);
    reset_n = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    issue(200, 7); wait_done(8, "200_7");
    check("200_7_q", dif.quotient, 28);  check("200_7_r", dif.remainder, 4);
    check("model_200_7", {e_q, e_r}, {8'd28, 8'd4});
    check("200_7_dbz", dif.div_by_zero, 0);

    @(negedge clk);
    issue(255, 1); wait_done(8, "255_1");
    check("255_1_q", dif.quotient, 255); check("255_1_r", dif.remainder, 0);
    issue(0, 13); wait_done(8, "0_13");
    check("0_13_q", dif.quotient, 0);    check("0_13_r", dif.remainder, 0);

    @(negedge clk);
    issue(5, 0); wait_done(0, "5_0");
    check("5_0_q", dif.quotient, 8'hFF); check("5_0_r", dif.remainder, 5);
    check("5_0_dbz", dif.div_by_zero, 1);
    check("model_5_0", {e_q, e_r, 7'd0, e_dbz}, {8'hFF, 8'd5, 8'd1});

    @(negedge clk);
    issue(3, 9); wait_done(EARLY ? 0 : 8, "3_9");
    check("3_9_q", dif.quotient, 0);     check("3_9_r", dif.remainder, 3);

    @(negedge clk);
    issue(100, 3);
    @(negedge clk); @(negedge clk);
    dif.start = 1; dif.dividend = 50; dif.divisor = 5;
    @(negedge clk);
    dif.start = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    check("midcalc_rst_busy", dif.busy, 0);
    check("midcalc_rst_quot", dif.quotient, 0);
    check("midcalc_rst_rem", dif.remainder, 0);
    @(negedge clk);
    reset_n = 1;
    done_seen = 0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", done_seen, 0);
    issue(100, 3); wait_done(8, "100_3");
    check("100_3_q", dif.quotient, 33);  check("100_3_r", dif.remainder, 1);

    // Random traffic: starts while busy and operand churn are checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      dif.start    = ($urandom_range(0, 2) == 0);
      dif.dividend = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       dif.divisor = 0;
        1, 2:    dif.divisor = WIDTH'($urandom_range(1, 4));
        default: dif.divisor = WIDTH'($urandom);
      endcase
    end
    @(negedge clk);
    dif.start = 0;
    repeat (12) @(negedge clk);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
